serial_adder_ctrl: RTL

//   Bit-serial adder controller: sequences one 1-bit full-adder cell (fullAdder:
//   In1,In2,Cin -> Sum,Cout) over WIDTH clock cycles, LSB first, to add two

---
 rtl/serial_adder_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//   state  | meaning
//   S_IDLE | waiting for start; result outputs held
//   S_RUN  | one operand bit added per cycle
//   S_DONE | one-cycle done pulse; result valid
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        carry_d = fa_cout;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // Final bit: capture carry-out (and MSB carry-in vs carry-out) as the result flags.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
